// File: rtl/npu_mem_pkg.sv
// Shared sizes, load-region layout, FSM states and result-bank map
// for the NPU memory and load-control shell.
package npu_mem_pkg;

  localparam int RES_DEPTH = 2400;
  localparam int RES_AW    = 12;

  localparam int N_IMG = 224;
  localparam int N_C12 = 320;
  localparam int N_C34 = 9248;
  localparam int N_C5  = 9248;
  localparam int N_D1  = 4103;
  localparam int N_D2  = 98;

  localparam int BASE_IMG = 0;
  localparam int BASE_C12 = BASE_IMG + N_IMG;
  localparam int BASE_C34 = BASE_C12 + N_C12;
  localparam int BASE_C5  = BASE_C34 + N_C34;
  localparam int BASE_D1  = BASE_C5 + N_C5;
  localparam int BASE_D2  = BASE_D1 + N_D1;
  localparam int LOAD_END = BASE_D2 + N_D2;

  localparam int RES_POOL1_BASE  = 0;
  localparam int RES_POOL2_BASE  = 1568;
  localparam int RES_FLAT_BASE   = 1856;
  localparam int RES_DENSE1_BASE = 2368;

  typedef enum logic [2:0] {RG_IMG, RG_C12, RG_C34, RG_C5, RG_D1, RG_D2} region_e;
  typedef enum logic [2:0] {ST_IDLE, ST_ARM, ST_LOAD, ST_LOADED, ST_RUN, ST_DONE} state_e;

  function automatic logic [13:0] region_last(input region_e r);
    case (r)
      RG_IMG:  return 14'(N_IMG - 1);
      RG_C12:  return 14'(N_C12 - 1);
      RG_C34:  return 14'(N_C34 - 1);
      RG_C5:   return 14'(N_C5 - 1);
      RG_D1:   return 14'(N_D1 - 1);
      default: return 14'(N_D2 - 1);
    endcase
  endfunction

  function automatic logic [14:0] region_base(input region_e r);
    case (r)
      RG_IMG:  return 15'(BASE_IMG);
      RG_C12:  return 15'(BASE_C12);
      RG_C34:  return 15'(BASE_C34);
      RG_C5:   return 15'(BASE_C5);
      RG_D1:   return 15'(BASE_D1);
      default: return 15'(BASE_D2);
    endcase
  endfunction

  function automatic region_e region_next(input region_e r);
    case (r)
      RG_IMG:  return RG_C12;
      RG_C12:  return RG_C34;
      RG_C34:  return RG_C5;
      RG_C5:   return RG_D1;
      default: return RG_D2;
    endcase
  endfunction

endpackage

// File: rtl/npu_res_bank.sv
// One 8-bit layer-result bank: single write port, registered read port.
module npu_res_bank
  import npu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [RES_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [RES_AW-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [RES_DEPTH];

  // Addresses past the bank depth are dropped on write and read back as zero.
  always_ff @(posedge clk) begin
    if (we && (waddr < RES_AW'(RES_DEPTH)))
      mem[waddr] <= wdata;
    rdata <= (raddr < RES_AW'(RES_DEPTH)) ? mem[raddr] : 8'h00;
  end

endmodule

// File: rtl/npu_mem_top.sv
// Host load sequencer, parameter/image memories, result banks and D_OUT
// presentation for the CNN inference core.
module npu_mem_top
  import npu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       writedata,
  input  logic [31:0]       control_reg,
  output logic [7:0]        D_OUT,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_class,
  input  logic [7:0]        img_raddr,
  output logic [31:0]       img_rdata,
  input  logic [8:0]        c12_raddr,
  output logic [7:0]        c12_rdata,
  input  logic [13:0]       c34_raddr,
  output logic [7:0]        c34_rdata,
  input  logic [13:0]       c5_raddr,
  output logic [7:0]        c5_rdata,
  input  logic [12:0]       d1_raddr,
  output logic [31:0]       d1_rdata,
  input  logic [6:0]        d2_raddr,
  output logic [31:0]       d2_rdata,
  input  logic              res_we,
  input  logic [1:0]        res_wbank,
  input  logic [RES_AW-1:0] res_waddr,
  input  logic [7:0]        res_wdata,
  input  logic [RES_AW-1:0] res_raddr,
  output logic [31:0]       res_rdata,
  output logic [2:0]        fsm_state,
  output logic [14:0]       load_count
);

  state_e            state, state_next;
  region_e           region;
  logic [13:0]       offset;
  logic              load_prev, rb_q, capture, arm, running;
  logic [1:0]        bank_q;
  logic [3:0]        class_reg;
  logic [RES_AW-1:0] bank_raddr;
  logic [7:0]        bank_rdata [4];

  logic ctrl_load, ctrl_start, ctrl_rb, load_rise, load_last, ctrl_unused;
  assign ctrl_load   = control_reg[0];
  assign ctrl_start  = control_reg[1];
  assign ctrl_rb     = control_reg[3];
  assign ctrl_unused = ^{control_reg[31:18], control_reg[2]};
  // A held LOAD after completion must not re-arm, so entry into ARM needs a fresh LOAD edge.
  assign load_rise   = ctrl_load & ~load_prev;
  assign load_last   = (region == RG_D2) && (offset == region_last(RG_D2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:            if (load_rise) state_next = ST_ARM;
      ST_ARM:             state_next = ST_LOAD;
      ST_LOAD:            if (ctrl_load && load_last) state_next = ST_LOADED;
      ST_LOADED, ST_DONE: if (ctrl_start) state_next = ST_RUN;
                          else if (load_rise) state_next = ST_ARM;
      ST_RUN:             if (core_done) state_next = ST_DONE;
      default:            state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    core_start = ((state == ST_LOADED) || (state == ST_DONE)) && ctrl_start;
    capture    = (state == ST_LOAD) && ctrl_load;
    arm        = (state == ST_ARM);
    running    = (state == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      region    <= RG_IMG;
      offset    <= '0;
      load_prev <= 1'b0;
      class_reg <= '0;
      rb_q      <= 1'b0;
      bank_q    <= '0;
    end else begin
      load_prev <= ctrl_load;
      rb_q      <= ctrl_rb;
      bank_q    <= control_reg[5:4];
      if (running && core_done) class_reg <= core_class;
      if (arm) begin
        region <= RG_IMG;
        offset <= '0;
      end else if (capture) begin
        if ((offset == region_last(region)) && (region != RG_D2)) begin
          region <= region_next(region);
          offset <= '0;
        end else begin
          offset <= offset + 14'd1;
        end
      end
    end
  end

  logic [31:0] img_mem [N_IMG];
  logic [7:0]  c12_mem [N_C12];
  logic [7:0]  c34_mem [N_C34];
  logic [7:0]  c5_mem  [N_C5];
  logic [31:0] d1_mem  [N_D1];
  logic [31:0] d2_mem  [N_D2];

  // Byte-wide conv regions keep only the low byte of each host word.
  always_ff @(posedge clk) begin
    if (capture && region == RG_IMG) img_mem[offset[7:0]]  <= writedata;
    if (capture && region == RG_C12) c12_mem[offset[8:0]]  <= writedata[7:0];
    if (capture && region == RG_C34) c34_mem[offset]       <= writedata[7:0];
    if (capture && region == RG_C5)  c5_mem[offset]        <= writedata[7:0];
    if (capture && region == RG_D1)  d1_mem[offset[12:0]]  <= writedata;
    if (capture && region == RG_D2)  d2_mem[offset[6:0]]   <= writedata;
    img_rdata <= img_mem[img_raddr];
    c12_rdata <= c12_mem[c12_raddr];
    c34_rdata <= c34_mem[c34_raddr];
    c5_rdata  <= c5_mem[c5_raddr];
    d1_rdata  <= d1_mem[d1_raddr];
    d2_rdata  <= d2_mem[d2_raddr];
  end

  assign bank_raddr = running ? res_raddr : control_reg[17:6];

  for (genvar b = 0; b < 4; b++) begin : g_bank
    npu_res_bank u_bank (
      .clk   (clk),
      .we    (res_we && running && (res_wbank == 2'(b))),
      .waddr (res_waddr),
      .wdata (res_wdata),
      .raddr (bank_raddr),
      .rdata (bank_rdata[b])
    );
  end

  assign res_rdata = {bank_rdata[3], bank_rdata[2], bank_rdata[1], bank_rdata[0]};

  always_comb begin
    if (running)   D_OUT = 8'h00;
    else if (rb_q) D_OUT = bank_rdata[bank_q];
    else           D_OUT = {4'b0, class_reg};
  end

  assign fsm_state  = state;
  assign load_count = region_base(region) + 15'(offset);

endmodule

// File: tb/tb_npu_mem_top.sv
// Self-checking bench for npu_mem_top: random load stream checked against
// a flat-array reference of the host stream and the region size table.
module tb_npu_mem_top;
  import npu_mem_pkg::*;

  localparam int TOTAL = 23241;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] writedata, control_reg;
  logic [7:0]  D_OUT;
  logic        core_start, core_done;
  logic [3:0]  core_class;
  logic [7:0]  img_raddr;
  logic [31:0] img_rdata;
  logic [8:0]  c12_raddr;
  logic [7:0]  c12_rdata;
  logic [13:0] c34_raddr, c5_raddr;
  logic [7:0]  c34_rdata, c5_rdata;
  logic [12:0] d1_raddr;
  logic [31:0] d1_rdata;
  logic [6:0]  d2_raddr;
  logic [31:0] d2_rdata;
  logic        res_we;
  logic [1:0]  res_wbank;
  logic [11:0] res_waddr, res_raddr;
  logic [7:0]  res_wdata;
  logic [31:0] res_rdata;
  logic [2:0]  fsm_state;
  logic [14:0] load_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] stream [TOTAL];

  npu_mem_top dut (
    .clk(clk), .reset(reset), .writedata(writedata), .control_reg(control_reg),
    .D_OUT(D_OUT), .core_start(core_start), .core_done(core_done), .core_class(core_class),
    .img_raddr(img_raddr), .img_rdata(img_rdata), .c12_raddr(c12_raddr), .c12_rdata(c12_rdata),
    .c34_raddr(c34_raddr), .c34_rdata(c34_rdata), .c5_raddr(c5_raddr), .c5_rdata(c5_rdata),
    .d1_raddr(d1_raddr), .d1_rdata(d1_rdata), .d2_raddr(d2_raddr), .d2_rdata(d2_rdata),
    .res_we(res_we), .res_wbank(res_wbank), .res_waddr(res_waddr), .res_wdata(res_wdata),
    .res_raddr(res_raddr), .res_rdata(res_rdata), .fsm_state(fsm_state), .load_count(load_count)
  );

  always #5 clk = ~clk;

  function automatic int regionSize(input int r);
    case (r)
      0: return 224;
      1: return 320;
      2: return 9248;
      3: return 9248;
      4: return 4103;
      default: return 98;
    endcase
  endfunction

  function automatic void locate(input int idx, output int r, output int off);
    int base;
    base = 0;
    r = 0;
    off = idx;
    for (int k = 0; k < 6; k++) begin
      if (idx >= base && idx < base + regionSize(k)) begin
        r = k;
        off = idx - base;
      end
      base += regionSize(k);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] ctrl, input logic [31:0] wd);
    control_reg = ctrl;
    writedata   = wd;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reads one stream word back through the matching parameter read port.
  task automatic checkStreamWord(input int idx);
    int r, off;
    logic [31:0] got, exp;
    locate(idx, r, off);
    img_raddr = 8'(off);
    c12_raddr = 9'(off);
    c34_raddr = 14'(off);
    c5_raddr  = 14'(off);
    d1_raddr  = 13'(off);
    d2_raddr  = 7'(off);
    tick();
    case (r)
      0: got = img_rdata;
      1: got = {24'b0, c12_rdata};
      2: got = {24'b0, c34_rdata};
      3: got = {24'b0, c5_rdata};
      4: got = d1_rdata;
      default: got = d2_rdata;
    endcase
    exp = (r >= 1 && r <= 3) ? {24'b0, stream[idx][7:0]} : stream[idx];
    checkOutput($sformatf("mem[%0d]", idx), got, exp);
  endtask

  initial begin
    int spots [16];
    logic [7:0] rb0;
    logic [3:0] cls;

    reset = 1'b0; writedata = '0; control_reg = '0; core_done = 1'b0; core_class = '0;
    img_raddr = '0; c12_raddr = '0; c34_raddr = '0; c5_raddr = '0; d1_raddr = '0; d2_raddr = '0;
    res_we = 1'b0; res_wbank = '0; res_waddr = '0; res_wdata = '0; res_raddr = '0;
    for (int i = 0; i < TOTAL; i++) stream[i] = $urandom;
    stream[0]   = 32'h0102_0304;
    stream[224] = {stream[224][31:8], 8'h5A};

    repeat (3) tick();
    checkOutput("reset_state", 32'(fsm_state), 32'(ST_IDLE));
    checkOutput("reset_dout", 32'(D_OUT), 32'h0);
    checkOutput("reset_count", 32'(load_count), 32'h0);
    reset = 1'b1;
    tick();

    control_reg = 32'h2;
    #1 checkOutput("start_idle_pulse", 32'(core_start), 32'h0);
    tick();
    checkOutput("start_idle_state", 32'(fsm_state), 32'(ST_IDLE));

    applyStimulus(32'h1, $urandom);
    checkOutput("arm_state", 32'(fsm_state), 32'(ST_ARM));
    applyStimulus(32'h1, $urandom);
    for (int i = 0; i < 10; i++) applyStimulus(32'h1, $urandom);
    checkOutput("partial_count", 32'(load_count), 32'd10);
    #2 reset = 1'b0;
    #1;
    checkOutput("midload_reset_state", 32'(fsm_state), 32'(ST_IDLE));
    checkOutput("midload_reset_count", 32'(load_count), 32'h0);
    control_reg = '0;
    tick();
    reset = 1'b1;
    tick();

    applyStimulus(32'h1, $urandom);
    applyStimulus(32'h1, $urandom);
    for (int i = 0; i < TOTAL; i++) begin
      if (i == 644) begin
        for (int p = 0; p < 5; p++) applyStimulus(32'h0, $urandom);
        checkOutput("pause_count", 32'(load_count), 32'd644);
        checkOutput("pause_state", 32'(fsm_state), 32'(ST_LOAD));
      end
      applyStimulus(32'h1, stream[i]);
    end
    checkOutput("loaded_state", 32'(fsm_state), 32'(ST_LOADED));
    checkOutput("loaded_count", 32'(load_count), 32'd23241);

    for (int i = 0; i < 3; i++) applyStimulus(32'h1, 32'hFFFF_FFFF);
    checkOutput("held_load_state", 32'(fsm_state), 32'(ST_LOADED));
    applyStimulus(32'h0, 32'h0);

    img_raddr = 8'd0;
    c12_raddr = 9'd0;
    tick();
    checkOutput("img0_bytes", img_rdata, 32'h0102_0304);
    checkOutput("c12_0", 32'(c12_rdata), 32'h5A);

    spots = '{0, 223, 224, 543, 544, 643, 644, 645, 9791, 9792, 19039, 19040, 23142, 23143, 23240, 1000};
    foreach (spots[k]) checkStreamWord(spots[k]);
    for (int k = 0; k < 12; k++) checkStreamWord(int'($urandom_range(TOTAL - 1, 0)));

    control_reg = 32'h2;
    #1 checkOutput("start_loaded_pulse", 32'(core_start), 32'h1);
    tick();
    checkOutput("run_state", 32'(fsm_state), 32'(ST_RUN));
    control_reg = 32'h0;
    #1 checkOutput("start_one_cycle", 32'(core_start), 32'h0);

    applyStimulus(32'h1 | 32'h8 | (32'd2 << 4) | (32'd1570 << 6), 32'h0);
    checkOutput("run_ignores_load", 32'(fsm_state), 32'(ST_RUN));
    checkOutput("run_dout_zero", 32'(D_OUT), 32'h0);
    control_reg = 32'h0;
    rb0 = 8'($urandom);
    res_we = 1'b1; res_wbank = 2'd2; res_waddr = 12'd1570; res_wdata = 8'hA3;
    tick();
    res_wbank = 2'd0; res_waddr = 12'd2368; res_wdata = rb0;
    tick();
    res_we = 1'b0;
    res_raddr = 12'd1570;
    tick();
    checkOutput("core_read_bank2", 32'(res_rdata[23:16]), 32'hA3);

    core_done = 1'b1; core_class = 4'd7;
    tick();
    core_done = 1'b0;
    checkOutput("done_state", 32'(fsm_state), 32'(ST_DONE));
    checkOutput("done_class", 32'(D_OUT), 32'h07);

    res_we = 1'b1; res_wbank = 2'd2; res_waddr = 12'd1570; res_wdata = 8'hFF;
    tick();
    res_we = 1'b0;

    applyStimulus(32'h8 | (32'd2 << 4) | (32'd1570 << 6), 32'h0);
    checkOutput("readback_b2_1570", 32'(D_OUT), 32'hA3);
    applyStimulus(32'h8 | (32'd0 << 4) | (32'd2368 << 6), 32'h0);
    checkOutput("readback_b0_2368", 32'(D_OUT), 32'(rb0));
    applyStimulus(32'h8 | (32'd2 << 4) | (32'd2400 << 6), 32'h0);
    checkOutput("readback_oob", 32'(D_OUT), 32'h0);
    applyStimulus(32'h0, 32'h0);
    checkOutput("class_after_rb", 32'(D_OUT), 32'h07);

    control_reg = 32'h3;
    #1 checkOutput("start_wins_pulse", 32'(core_start), 32'h1);
    tick();
    checkOutput("start_wins_state", 32'(fsm_state), 32'(ST_RUN));
    control_reg = 32'h0;
    cls = 4'($urandom);
    core_done = 1'b1; core_class = cls;
    tick();
    core_done = 1'b0;
    checkOutput("second_class", 32'(D_OUT), {28'b0, cls});

    applyStimulus(32'h2, 32'h0);
    checkOutput("rerun_state", 32'(fsm_state), 32'(ST_RUN));
    control_reg = 32'h0;
    #2 reset = 1'b0;
    #1;
    checkOutput("midrun_reset_state", 32'(fsm_state), 32'(ST_IDLE));
    checkOutput("midrun_reset_start", 32'(core_start), 32'h0);
    checkOutput("midrun_reset_dout", 32'(D_OUT), 32'h0);
    tick();
    reset = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/npu_mem_top.md
Name: npu_mem_top

Overview:
- Memory and load-control shell of the CNN accelerator (MNIST-class network: conv1/2+pool, conv3/4+pool, conv5, dense1, dense2).
- Accepts a host word stream that fills the image and parameter memories in a fixed order. Starts the inference core on command. Holds the layer-result banks and presents either the class index or a result-bank readback byte on D_OUT.
- The inference datapath is a sub-module driven through the interface defined here.

Parameters:
- RES_DEPTH, 2400, depth of each of the 4 result banks.
- RES_AW, 12, result-bank address width.
- N_IMG, 224, image words (32-bit).
- N_C12, 320, conv1/2 parameter words (byte).
- N_C34, 9248, conv3/4 parameter words (byte).
- N_C5, 9248, conv5 parameter words (byte).
- N_D1, 4103, dense1 words (32-bit).
- N_D2, 98, dense2 words (32-bit).

Ports:
- clk  in  1  system clock; every register in the block uses this single clock.
- reset  in  1  asynchronous, active-low reset.
- writedata  in  32  host load word.
- control_reg  in  32  command register:
  - bit0 = LOAD.
  - bit1 = START.
  - bit3 = READBACK.
  - bits[5:4] = readback bank.
  - bits[17:6] = readback address.
- D_OUT  out  8  class index {4'b0, idx[3:0]}, or the readback byte when READBACK=1.

Behaviour:
- FSM states: IDLE, ARM, LOAD, LOADED, RUN, DONE.
- Reset (async assert, sync release): FSM to IDLE, load counters 0, D_OUT 0, class register 0. Memory contents are not cleared.
- IDLE/LOADED/DONE with LOAD=1 goes to ARM. ARM lasts exactly one cycle and discards writedata.
- LOAD state:
  - Each clock edge with LOAD=1 captures one word at the current region and offset, then increments.
  - Region order: IMG, C12, C34, C5, D1, D2.
  - Region advance is seamless: the word after the last word of a region is offset 0 of the next region.
  - LOAD=0 in LOAD state pauses capture. The counter holds and resumes on the next cycle with LOAD=1, with no re-ARM.
- After word 23241 (all regions full), go to LOADED. Further words are ignored, even if LOAD stays 1.
- Word packing:
  - IMG, D1 and D2 store the full 32 bits; byte0 = writedata[31:24] (first byte in stream order).
  - C12, C34 and C5 store writedata[7:0].
- START=1 for one cycle in LOADED or DONE goes to RUN and asserts core_start for 1 cycle.
  - START in IDLE/ARM/LOAD/RUN is ignored.
  - LOAD is ignored in RUN.
  - If START and LOAD are both 1 on the same cycle, START wins when it is legal; otherwise LOAD is processed.
- RUN:
  - The core owns all parameter read ports and the result-bank write port.
  - On core_done, latch class index [3:0] and go to DONE.
- Result-bank memory map:
  - 0..1567: pool1 output, channel c in bank c%4.
  - 1568..1855: pool2 output.
  - 1856..2367: conv5 flatten output, bank0 only, sequential.
  - 2368..2399: dense1 output, bank0 only.
- D_OUT, READBACK=0: class register.
- D_OUT, READBACK=1: registered read of bank[ctrl[5:4]][ctrl[17:6]], 1-cycle latency.
  - Readback is allowed in any state except RUN; D_OUT = 0 in RUN.
  - An address ≥ RES_DEPTH returns 0.
- Reset mid-LOAD or mid-RUN: the FSM returns to IDLE, so a full reload is required. core_start is deasserted.

Decomposition:
- Package npu_mem_pkg holds:
  - region enum;
  - N_* sizes and cumulative region base offsets (0, 224, 544, 9792, 19040, 23143, end 23241);
  - result-bank layer base addresses.
- Sub-module npu_res_bank: single 8-bit bank, 1 write + 1 read port, synchronous read; instantiated 4 times.
- The inference core is a separate block outside this spec.

Test Plan:
- Reset then idle → D_OUT=0, FSM IDLE; apply LOAD with random writedata, drop reset mid-stream → counter back to 0, state IDLE.
- Load stream (ARM cycle + 23241 words, counting pattern):
  - image word 0 = 32'h0102_0304 → IMG[0] bytes 01,02,03,04;
  - word 224 = 32'hxxxx_xx5A → C12[0]=8'h5A;
  - word 23240 → D2[97];
  - state LOADED.
- LOAD held 3 cycles after completion with writedata=32'hFFFF_FFFF → D2[97] unchanged, no overwrite of IMG[0].
- START pulse in IDLE → no core_start; START in LOADED → core_start high 1 cycle; core_done with idx=7 → D_OUT=8'h07, state DONE.
- Readback:
  - Preload bank2[1570]=8'hA3; READBACK=1, bank=2, addr=1570 → D_OUT=8'hA3 one cycle later.
  - addr=2400 → D_OUT=0.
- LOAD deasserted for 5 cycles mid-C34 → capture resumes at the next offset, no word lost or duplicated.
